// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store DMA bridge.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package lsu_pkg;

    localparam logic [7:0] OPC_RD = 8'h01;
    localparam logic [7:0] OPC_WR = 8'h03;

    localparam int HOST_AW  = 40;
    localparam int LOCAL_AW = 12;

    // Command header geometry; the length field is 16 bits wide on the wire,
    // so LEN_W above 16 would run into the opcode byte.
    localparam int HDR_W         = 128;
    localparam int HDR_LOCAL_LSB = 0;
    localparam int HDR_HOST_LSB  = 16;
    localparam int HDR_LEN_LSB   = 56;
    localparam int HDR_LEN_MAXW  = 16;
    localparam int HDR_OPC_LSB   = 72;

    typedef struct packed {
        logic [HDR_W-HDR_OPC_LSB-9:0]          rsvd;
        logic [7:0]                            opcode;
        logic [HDR_LEN_MAXW-1:0]               len;
        logic [HOST_AW-1:0]                    host_addr;
        logic [HDR_HOST_LSB-LOCAL_AW-1:0]      pad;
        logic [LOCAL_AW-1:0]                   local_addr;
    } hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_HDR,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } lsu_state_t;

    function automatic hdr_t build_hdr(input logic                    rwn,
                                       input logic [HOST_AW-1:0]      host_addr,
                                       input logic [LOCAL_AW-1:0]     local_addr,
                                       input logic [HDR_LEN_MAXW-1:0] len);
        hdr_t hdr;
        hdr            = '0;
        hdr.local_addr = local_addr;
        hdr.host_addr  = host_addr;
        hdr.len        = len;
        hdr.opcode     = rwn ? OPC_RD : OPC_WR;
        return hdr;
    endfunction

endpackage

// File: rtl/lsu_rr_arbiter.sv
// Round-robin pick: first requester at or after rr_ptr, modulo NUM_CH.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module lsu_rr_arbiter #(
    parameter int NUM_CH = 2,
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  rr_ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [PTR_W-1:0]  idx,
    output logic              any
);

    int               cand;
    logic [PTR_W-1:0] cand_idx;

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        grant    = '0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_idx = cand[PTR_W-1:0];
            if (req[cand_idx]) begin
                grant           = '0;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/lsu_dma_bridge.sv
// Arbitrates core load/store descriptors onto one DMA path, one transaction at a time.
// Latency: grant 1 cycle after request; header 1 cycle after dma_resp; done 1 cycle after last beat.
// Backpressure: beats pass through combinationally, so dma_wready / core_wvalid / dma_rvalid stall the burst.
module lsu_dma_bridge
    import lsu_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 128,
    parameter int LEN_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          core_req,
    input  logic [NUM_CH-1:0]          core_rwn,
    input  logic [NUM_CH*HOST_AW-1:0]  core_host_addr,
    input  logic [NUM_CH*LOCAL_AW-1:0] core_local_addr,
    input  logic [NUM_CH*LEN_W-1:0]    core_len,
    output logic [NUM_CH-1:0]          core_grant,
    input  logic [NUM_CH-1:0]          core_wvalid,
    input  logic [NUM_CH*DATA_W-1:0]   core_wdata,
    output logic [NUM_CH-1:0]          core_wready,
    output logic [NUM_CH-1:0]          core_rvalid,
    output logic [DATA_W-1:0]          core_rdata,
    output logic [NUM_CH-1:0]          core_done,
    output logic                       dma_req,
    input  logic                       dma_resp,
    output logic                       dma_wvalid,
    output logic [DATA_W-1:0]          dma_wdata,
    input  logic                       dma_wready,
    input  logic                       dma_rvalid,
    input  logic [DATA_W-1:0]          dma_rdata,
    output logic                       dma_rready,
    output logic                       err_stray
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    lsu_state_t        state, state_nxt;
    logic [PTR_W-1:0]  owner, rr_ptr, arb_idx;
    logic [NUM_CH-1:0] arb_grant, grant_q;
    logic              arb_any;
    logic              rwn_q, err_q;
    logic [HOST_AW-1:0]  host_q;
    logic [LOCAL_AW-1:0] local_q;
    logic [LEN_W-1:0]  len_q, beat_cnt, beat_cnt_inc;
    logic              beat_hs, last_beat, latch_desc;
    hdr_t              hdr;
    logic [DATA_W-1:0] hdr_ext;

    logic [HOST_AW-1:0]  host_ch  [NUM_CH];
    logic [LOCAL_AW-1:0] local_ch [NUM_CH];
    logic [LEN_W-1:0]    len_ch   [NUM_CH];
    logic [DATA_W-1:0]   wdata_ch [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign host_ch[g]  = core_host_addr[g*HOST_AW +: HOST_AW];
        assign local_ch[g] = core_local_addr[g*LOCAL_AW +: LOCAL_AW];
        assign len_ch[g]   = core_len[g*LEN_W +: LEN_W];
        assign wdata_ch[g] = core_wdata[g*DATA_W +: DATA_W];
    end

    lsu_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req    (core_req),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    assign latch_desc   = (state == ST_IDLE) && arb_any;
    assign beat_cnt_inc = beat_cnt + LEN_W'(1);
    // beat_cnt never exceeds len-1 before the increment, so a full-scale len cannot wrap.
    assign last_beat    = (beat_cnt_inc == len_q);
    assign hdr          = build_hdr(rwn_q, host_q, local_q, HDR_LEN_MAXW'(len_q));

    // Header is zero-extended onto the data bus.
    always_comb begin
        hdr_ext            = '0;
        hdr_ext[HDR_W-1:0] = hdr;
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and all state-decoded outputs; everything idles at 0 outside its phase.
    always_comb begin
        state_nxt   = state;
        dma_req     = 1'b0;
        dma_wvalid  = 1'b0;
        dma_wdata   = '0;
        dma_rready  = 1'b0;
        core_wready = '0;
        core_rvalid = '0;
        core_rdata  = '0;
        core_done   = '0;
        beat_hs     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                dma_req = 1'b1;
                if (dma_resp) begin
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                dma_wvalid = 1'b1;
                dma_wdata  = hdr_ext;
                if (dma_wready) begin
                    if (len_q == '0) begin
                        state_nxt = ST_DONE;
                    end else if (rwn_q) begin
                        state_nxt = ST_RDATA;
                    end else begin
                        state_nxt = ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                dma_wvalid         = core_wvalid[owner];
                dma_wdata          = wdata_ch[owner];
                core_wready[owner] = dma_wready;
                beat_hs            = core_wvalid[owner] & dma_wready;
                if (beat_hs && last_beat) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_RDATA: begin
                dma_rready         = 1'b1;
                core_rvalid[owner] = dma_rvalid;
                core_rdata         = dma_rdata;
                beat_hs            = dma_rvalid;
                if (beat_hs && last_beat) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                core_done[owner] = 1'b1;
                state_nxt        = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Descriptor latch, grant pulse, beat counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= '0;
            rr_ptr   <= '0;
            rwn_q    <= 1'b0;
            host_q   <= '0;
            local_q  <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            grant_q  <= '0;
        end else begin
            grant_q <= '0;
            if (latch_desc) begin
                owner    <= arb_idx;
                rwn_q    <= core_rwn[arb_idx];
                host_q   <= host_ch[arb_idx];
                local_q  <= local_ch[arb_idx];
                len_q    <= len_ch[arb_idx];
                grant_q  <= arb_grant;
                beat_cnt <= '0;
            end
            if (beat_hs) begin
                beat_cnt <= beat_cnt_inc;
            end
            if (state == ST_DONE) begin
                beat_cnt <= '0;
                rr_ptr   <= (owner == PTR_W'(NUM_CH - 1)) ? '0 : owner + PTR_W'(1);
            end
        end
    end

    // Read beats arriving outside a load burst are dropped and flagged until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (dma_rvalid && (state != ST_RDATA)) begin
            err_q <= 1'b1;
        end
    end

    assign core_grant = grant_q;
    assign err_stray  = err_q;

endmodule

// File: tb/tb_lsu_dma_bridge.sv
module tb_lsu_dma_bridge;

    localparam int NCH = 4;
    localparam int DW  = 128;
    localparam int LW  = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NCH-1:0]     core_req, core_rwn, core_grant, core_wvalid, core_wready, core_rvalid, core_done;
    logic [NCH*40-1:0]  core_host_addr;
    logic [NCH*12-1:0]  core_local_addr;
    logic [NCH*LW-1:0]  core_len;
    logic [NCH*DW-1:0]  core_wdata;
    logic [DW-1:0]      core_rdata, dma_wdata, dma_rdata;
    logic               dma_req, dma_resp, dma_wvalid, dma_wready, dma_rvalid, dma_rready, err_stray;

    always #5 clk = ~clk;

    lsu_dma_bridge #(.NUM_CH(NCH), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_req        (core_req),
        .core_rwn        (core_rwn),
        .core_host_addr  (core_host_addr),
        .core_local_addr (core_local_addr),
        .core_len        (core_len),
        .core_grant      (core_grant),
        .core_wvalid     (core_wvalid),
        .core_wdata      (core_wdata),
        .core_wready     (core_wready),
        .core_rvalid     (core_rvalid),
        .core_rdata      (core_rdata),
        .core_done       (core_done),
        .dma_req         (dma_req),
        .dma_resp        (dma_resp),
        .dma_wvalid      (dma_wvalid),
        .dma_wdata       (dma_wdata),
        .dma_wready      (dma_wready),
        .dma_rvalid      (dma_rvalid),
        .dma_rdata       (dma_rdata),
        .dma_rready      (dma_rready),
        .err_stray       (err_stray)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: descriptors per core and the rotation pointer.
    int          m_ptr;
    bit          d_rwn   [NCH];
    logic [39:0] d_host  [NCH];
    logic [11:0] d_local [NCH];
    int          d_len   [NCH];

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int pick(input logic [NCH-1:0] m, input int p);
        for (int k = 0; k < NCH; k++) begin
            if (m[(p + k) % NCH]) return (p + k) % NCH;
        end
        return 0;
    endfunction

    function automatic logic [127:0] exp_hdr(input int c);
        logic [127:0] opc;
        opc = d_rwn[c] ? 128'h01 : 128'h03;
        return 128'(d_local[c]) | (128'(d_host[c]) << 16) | (128'(d_len[c]) << 56) | (opc << 72);
    endfunction

    task automatic set_desc(input int c, input bit rwn, input logic [39:0] host,
                            input logic [11:0] la, input int len);
        d_rwn[c] = rwn; d_host[c] = host; d_local[c] = la; d_len[c] = len;
        core_rwn[c]                  = rwn;
        core_host_addr[c*40 +: 40]   = host;
        core_local_addr[c*12 +: 12]  = la;
        core_len[c*LW +: LW]         = LW'(len);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_dma_wvalid"}, dma_wvalid, 0);
        check_eq({tag, "_dma_wdata"}, dma_wdata, 0);
        check_eq({tag, "_dma_req"}, dma_req, 0);
        check_eq({tag, "_dma_rready"}, dma_rready, 0);
        check_eq({tag, "_core_wready"}, core_wready, 0);
        check_eq({tag, "_core_rvalid"}, core_rvalid, 0);
        check_eq({tag, "_core_rdata"}, core_rdata, 0);
        check_eq({tag, "_core_grant"}, core_grant, 0);
        check_eq({tag, "_core_done"}, core_done, 0);
        check_eq({tag, "_err_stray"}, err_stray, 0);
    endtask

    // One transaction driven from the core side and the DMA side, checked against the model.
    task automatic run_txn(input logic [NCH-1:0] mask, input bit keep, input bit fresh,
                           input bit stall, input int abort_at, output int won);
        int w, len, sent, rcv, cyc, g_cyc, d_cyc, hs_cyc, n_g, n_d;
        bit rwn, hdr_done, granted, done, aborted;
        logic [NCH-1:0] own, g_seen, d_seen;
        logic [127:0] e_hdr;
        logic [127:0] wq[$];
        logic [127:0] rq[$];
        w = pick(mask, m_ptr); won = w;
        len = d_len[w]; rwn = d_rwn[w]; own = NCH'(1) << w; e_hdr = exp_hdr(w);
        for (int i = 0; i < len; i++) begin
            wq.push_back(rnd128());
            rq.push_back(rnd128());
        end
        sent = 0; rcv = 0; cyc = 0; g_cyc = -1; d_cyc = -1; hs_cyc = -10; n_g = 0; n_d = 0;
        hdr_done = 0; granted = 0; done = 0; aborted = 0; g_seen = '0; d_seen = '0;
        if (fresh) begin
            @(posedge clk); #1;
        end
        core_req = core_req | mask;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (core_grant != '0) begin
                n_g++; g_seen = core_grant; g_cyc = cyc; granted = 1;
                check_eq("dma_req_at_grant", dma_req, 1);
                if (!keep) core_req[w] = 1'b0;
            end
            if (core_done != '0) begin
                n_d++; d_seen = core_done; d_cyc = cyc; done = 1;
            end
            if (done) break;
            dma_resp    = granted && !hdr_done && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            dma_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            core_wvalid = '0;
            dma_rvalid  = 1'b0;
            if (hdr_done && !rwn && sent < len) begin
                core_wvalid[w] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                core_wdata[w*DW +: DW] = wq[sent];
            end
            if (hdr_done && rwn && rcv < len) begin
                dma_rvalid = stall ? cyc[0] : 1'b1;
                dma_rdata  = rq[rcv];
            end
            #1;
            if (!hdr_done) begin
                if (dma_wvalid && dma_wready) begin
                    check_eq("header", dma_wdata, e_hdr);
                    hdr_done = 1; hs_cyc = cyc;
                end
            end else if (!rwn && sent < len) begin
                check_eq("wr_pass_vld", dma_wvalid, core_wvalid[w]);
                check_eq("wr_rdy_owner", core_wready, dma_wready ? own : '0);
                if (core_wvalid[w] && dma_wready) begin
                    check_eq("wr_beat_data", dma_wdata, wq[sent]);
                    sent++; hs_cyc = cyc;
                    if (abort_at >= 0 && sent == abort_at) begin
                        aborted = 1;
                        break;
                    end
                end
            end else if (rwn && rcv < len) begin
                check_eq("rd_owner_vld", core_rvalid, dma_rvalid ? own : '0);
                if (dma_rvalid) begin
                    check_eq("rd_rready", dma_rready, 1);
                    check_eq("rd_beat_data", core_rdata, rq[rcv]);
                    rcv++; hs_cyc = cyc;
                end
            end
        end
        if (aborted) begin
            @(posedge clk); #1;
            dma_rdata = rnd128();
            rst_n = 1'b0;
            #1;
            check_quiet("abort");
            core_req = '0; core_wvalid = '0; dma_resp = 0; dma_wready = 0; dma_rvalid = 0;
            m_ptr = 0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        end else begin
            check_eq("txn_done_seen", done, 1);
            check_eq("grant_count", n_g, 1);
            check_eq("grant_owner", g_seen, own);
            check_eq("grant_latency", g_cyc, fresh ? 1 : 2);
            check_eq("header_seen", hdr_done, 1);
            check_eq("beat_count", rwn ? rcv : sent, len);
            check_eq("done_count", n_d, 1);
            check_eq("done_owner", d_seen, own);
            check_eq("done_latency", d_cyc - hs_cyc, 1);
            m_ptr = (w + 1) % NCH;
            core_wvalid = '0; dma_rvalid = 0; dma_resp = 0; dma_wready = 0;
            if (!keep) core_req = '0;
        end
    endtask

    initial begin
        int won;
        logic [NCH-1:0] mk;
        rst_n = 1'b0;
        core_req = '0; core_rwn = '0; core_host_addr = '0; core_local_addr = '0; core_len = '0;
        core_wvalid = '0; core_wdata = '0;
        dma_resp = 0; dma_wready = 0; dma_rvalid = 0; dma_rdata = '0;
        m_ptr = 0;
        for (int c = 0; c < NCH; c++) set_desc(c, 0, '0, '0, 0);
        repeat (3) @(posedge clk);
        #1;
        dma_rdata = rnd128();
        #1;
        check_quiet("reset");
        rst_n = 1'b1;

        // Contention: all four cores requesting continuously, len 1 each.
        for (int c = 0; c < NCH; c++) set_desc(c, c[0], 40'($urandom()), 12'($urandom()), 1);
        for (int r = 0; r < 5; r++) begin
            run_txn(4'b1111, r < 4, r == 0, 0, -1, won);
            check_eq("rr_order", won, r % NCH);
        end

        // Single store on ch0.
        set_desc(0, 0, 40'h12_3456_7890, 12'hABC, 3);
        run_txn(4'b0001, 0, 1, 0, -1, won);

        // Load on ch1 with dma_rvalid toggling.
        set_desc(1, 1, 40'($urandom()), 12'($urandom()), 4);
        run_txn(4'b0010, 0, 1, 1, -1, won);

        // Zero-length store: header only.
        set_desc(2, 0, 40'($urandom()), 12'($urandom()), 0);
        run_txn(4'b0100, 0, 1, 0, -1, won);

        // Stray read beat while idle.
        @(posedge clk); #1;
        check_eq("stray_pre", err_stray, 0);
        dma_rvalid = 1'b1; dma_rdata = rnd128();
        #1;
        check_eq("stray_rready", dma_rready, 0);
        check_eq("stray_rvalid", core_rvalid, 0);
        @(posedge clk); #1;
        dma_rvalid = 1'b0;
        check_eq("stray_set", err_stray, 1);
        set_desc(3, 1, 40'($urandom()), 12'($urandom()), 3);
        run_txn(4'b1000, 0, 1, 1, -1, won);
        check_eq("stray_sticky", err_stray, 1);

        // Full-scale length, both directions.
        set_desc(1, 0, 40'($urandom()), 12'($urandom()), 15);
        run_txn(4'b0010, 0, 1, 1, -1, won);
        set_desc(2, 1, 40'($urandom()), 12'($urandom()), 15);
        run_txn(4'b0100, 0, 1, 1, -1, won);

        // Randomised traffic.
        for (int t = 0; t < 16; t++) begin
            for (int c = 0; c < NCH; c++)
                set_desc(c, 1'($urandom_range(0, 1)), 40'({$urandom(), $urandom()}),
                         12'($urandom()), int'($urandom_range(0, 15)));
            mk = NCH'($urandom_range(1, 15));
            run_txn(mk, 0, 1, 1'($urandom_range(0, 1)), -1, won);
        end

        // Reset after 2 of 5 store beats, then a clean store.
        set_desc(0, 0, 40'($urandom()), 12'($urandom()), 5);
        run_txn(4'b0001, 0, 1, 0, 2, won);
        set_desc(0, 0, 40'($urandom()), 12'($urandom()), 2);
        run_txn(4'b0001, 0, 1, 0, -1, won);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
